// File: rtl/sram_arb_pkg.sv
// Shared types and default sizes for the SRAM arbiter.
// The arbitration mode is chosen by the SRAM_ARB_RR_EN macro in sram_arb_pick.
package sram_arb_pkg;
  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 16;
  localparam int RD_CYC_DEF = 2;
  localparam int WR_CYC_DEF = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;
endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner selection between the CPU and debug requesters.
// SRAM_ARB_RR_EN defined: round-robin on ties; undefined: fixed CPU priority.
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic   cpu_req,
  input  logic   dbg_req,
  input  owner_t last,
  output owner_t win
);

`ifdef SRAM_ARB_RR_EN
  // On a tie the requester that was not granted last time wins.
  always_comb begin
    win = OWN_CPU;
    if (cpu_req && dbg_req) begin
      win = (last == OWN_CPU) ? OWN_DBG : OWN_CPU;
    end else if (dbg_req) begin
      win = OWN_DBG;
    end
  end
`else
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    win = OWN_CPU;
    if (dbg_req && !cpu_req) begin
      win = OWN_DBG;
    end
  end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester SRAM sequencer: owns CE/OE/WE timing and the multi-cycle access count.
// Arbitration mode selected by SRAM_ARB_RR_EN (see sram_arb_pick).
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_CYC = RD_CYC_DEF,
  parameter int WR_CYC = WR_CYC_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  // Handshake: req is a level held until the one-cycle ack; a req still high
  // when the arbiter returns to IDLE is treated as a new transaction.
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              owner,
  output logic              Mem_CE,
  output logic              Mem_OE,
  output logic              Mem_WE,
  output logic              Mem_UB,
  output logic              Mem_LB,
  output logic [ADDR_W-1:0] Mem_ADDR,
  output logic [DATA_W-1:0] Data_to_SRAM,
  input  logic [DATA_W-1:0] Data_from_SRAM,
  output logic              drive_en,
  output state_t            fsm_state
);

  localparam int MAX_CYC = (RD_CYC > WR_CYC) ? RD_CYC : WR_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count;
  logic             we_q;
  logic             last_cyc;
  owner_t           owner_q, last_q, win;

  sram_arb_pick u_pick (
    .cpu_req (cpu_req),
    .dbg_req (dbg_req),
    .last    (last_q),
    .win     (win)
  );

  assign last_cyc  = we_q ? (count == CNT_W'(WR_CYC - 1)) : (count == CNT_W'(RD_CYC - 1));
  assign owner     = owner_q;
  assign Mem_UB    = 1'b0;
  assign Mem_LB    = 1'b0;
  assign fsm_state = state_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      count        <= '0;
      we_q         <= 1'b0;
      Mem_ADDR     <= '0;
      Data_to_SRAM <= '0;
      owner_q      <= OWN_CPU;
      last_q       <= OWN_DBG;
      rdata        <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (cpu_req || dbg_req) begin
            owner_q <= win;
            last_q  <= win;
            count   <= '0;
            if (win == OWN_DBG) begin
              we_q         <= dbg_we;
              Mem_ADDR     <= dbg_addr;
              Data_to_SRAM <= dbg_wdata;
            end else begin
              we_q         <= cpu_we;
              Mem_ADDR     <= cpu_addr;
              Data_to_SRAM <= cpu_wdata;
            end
          end
        end
        ACCESS: begin
          count <= count + 1'b1;
          // Read data is sampled on the final OE-low cycle.
          if (last_cyc && !we_q) begin
            rdata <= Data_from_SRAM;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    Mem_CE   = 1'b1;
    Mem_OE   = 1'b1;
    Mem_WE   = 1'b1;
    drive_en = 1'b0;
    cpu_ack  = 1'b0;
    dbg_ack  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req || dbg_req) state_d = ACCESS;
      end
      ACCESS: begin
        Mem_CE = 1'b0;
        if (we_q) begin
          Mem_WE   = 1'b0;
          drive_en = 1'b1;
        end else begin
          Mem_OE = 1'b0;
        end
        if (last_cyc) state_d = DONE;
      end
      DONE: begin
        // Controls stay inactive here to give the SRAM write recovery.
        cpu_ack = (owner_q == OWN_CPU);
        dbg_ack = (owner_q == OWN_DBG);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
